// File: rtl/yacht_pkg.sv
// Shared types and constants for the Yacht Dice turn sequencer.
package yacht_pkg;

  typedef enum logic [3:0] {
    ST_INIT        = 4'd0,
    ST_TURN_START  = 4'd1,
    ST_WAIT        = 4'd2,
    ST_ROLL        = 4'd3,
    ST_SELECT      = 4'd4,
    ST_COMMIT      = 4'd5,
    ST_NEXT_PLAYER = 4'd6,
    ST_GAME_END    = 4'd7
  } state_t;

  localparam int BONUS_THRESH = 63;
  localparam int BONUS_VAL    = 35;
  localparam int UPPER_CATS   = 6;

endpackage

// File: rtl/yacht_cat_picker.sv
// Free-category search over one player's used mask: lowest free index and
// the nearest free index above (dir=1) or below (dir=0) cur, with wrap-around.
module yacht_cat_picker
  import yacht_pkg::*;
#(
  parameter int NUM_CAT = 12,
  parameter int CW      = $clog2(NUM_CAT)
) (
  input  logic [NUM_CAT-1:0] mask,
  input  logic [CW-1:0]      cur,
  input  logic               dir,
  output logic [CW-1:0]      first_free,
  output logic [CW-1:0]      next_free,
  output logic               any_free
);

  // Scan from far to near so the nearest free entry is written last.
  always_comb begin : search
    int idx;
    idx        = 0;
    any_free   = ~&mask;
    first_free = '0;
    next_free  = cur;
    for (int i = NUM_CAT - 1; i >= 0; i--) begin
      if (!mask[CW'(i)]) first_free = CW'(i);
      else               first_free = first_free;
    end
    for (int k = NUM_CAT - 1; k >= 1; k--) begin
      idx = dir ? (int'(cur) + k) : (int'(cur) - k);
      if (idx >= NUM_CAT) idx = idx - NUM_CAT;
      else if (idx < 0)   idx = idx + NUM_CAT;
      else                idx = idx;
      if (!mask[CW'(idx)]) next_free = CW'(idx);
      else                 next_free = next_free;
    end
  end

endmodule

// File: rtl/yacht_turn_ctrl.sv
// Multi-player Yacht Dice turn sequencer: rolls, category choice, scoring, winner.
// Optional upper-section bonus is compiled in when YACHT_UPPER_BONUS_EN is defined.
module yacht_turn_ctrl
  import yacht_pkg::*;
#(
  parameter  int NUM_PLAYERS = 2,
  parameter  int NUM_CAT     = 12,
  parameter  int MAX_ROLLS   = 3,
  parameter  int SCORE_W     = 9,
  localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW = $clog2(NUM_CAT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           btn_roll,
  input  logic                           btn_sel,
  input  logic                           btn_prev,
  input  logic                           btn_next,
  input  logic [4:0]                     hold_sw,
  input  logic [7:0]                     calc_score,
  output logic [3:0]                     current_state,
  output logic [PW-1:0]                  player_idx,
  output logic                           roll_trigger,
  output logic [1:0]                     roll_cnt,
  output logic                           dice_clear,
  output logic [CW-1:0]                  category_idx,
  output logic [3:0]                     round_num,
  output logic [NUM_CAT-1:0]             used_mask,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [PW-1:0]                  winner_idx,
  output logic                           tie
);

  localparam int SUM_W = ((SCORE_W > 8) ? SCORE_W : 8) + 2;

  state_t               state_q, state_d;
  logic [3:0]           cs_q;
  logic [PW-1:0]        player_q, player_d, winner_q, winner_d, win_s;
  logic [1:0]           roll_cnt_q, roll_cnt_d;
  logic [CW-1:0]        cat_q, cat_d;
  logic [3:0]           round_q, round_d;
  logic [NUM_CAT-1:0]   mask_q [NUM_PLAYERS];
  logic [NUM_CAT-1:0]   mask_d [NUM_PLAYERS];
  logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
  logic                 trig_q, trig_d, tie_q, tie_d, tie_s;
  logic [SCORE_W-1:0]   best_s, new_score_s;
  logic [SUM_W-1:0]     sum_s;
  logic [NUM_CAT-1:0]   cur_mask_s;
  logic [CW-1:0]        first_free_s, next_free_s;
  logic                 any_free_s, roll_ok_s;
`ifdef YACHT_UPPER_BONUS_EN
  logic [6:0]           upper_q [NUM_PLAYERS];
  logic [6:0]           upper_d [NUM_PLAYERS];
  logic                 bonus_q [NUM_PLAYERS];
  logic                 bonus_d [NUM_PLAYERS];
  logic [8:0]           upper_sum_s;
  logic                 bonus_hit_s;
`endif

  assign cur_mask_s = mask_q[player_q];
  // A first roll with any die held is refused.
  assign roll_ok_s  = btn_roll && (roll_cnt_q < 2'(MAX_ROLLS)) &&
                      !((roll_cnt_q == 2'd0) && (|hold_sw));

  yacht_cat_picker #(.NUM_CAT(NUM_CAT), .CW(CW)) u_picker (
    .mask       (cur_mask_s),
    .cur        (cat_q),
    .dir        (btn_next),
    .first_free (first_free_s),
    .next_free  (next_free_s),
    .any_free   (any_free_s)
  );

  // Saturating score update for the active player.
  always_comb begin
`ifdef YACHT_UPPER_BONUS_EN
    upper_sum_s = 9'(upper_q[player_q]) + 9'(calc_score);
    bonus_hit_s = (cat_q < CW'(UPPER_CATS)) && !bonus_q[player_q] &&
                  (upper_sum_s >= 9'(BONUS_THRESH));
    sum_s = SUM_W'(score_q[player_q]) + SUM_W'(calc_score) +
            (bonus_hit_s ? SUM_W'(BONUS_VAL) : SUM_W'(0));
`else
    sum_s = SUM_W'(score_q[player_q]) + SUM_W'(calc_score);
`endif
    if (sum_s > SUM_W'({SCORE_W{1'b1}})) new_score_s = '1;
    else                                 new_score_s = sum_s[SCORE_W-1:0];
  end

  // Highest score wins; the lowest index keeps ties.
  always_comb begin
    best_s = score_q[0];
    win_s  = '0;
    tie_s  = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_q[p] > best_s) begin
        best_s = score_q[p];
        win_s  = PW'(p);
        tie_s  = 1'b0;
      end else if (score_q[p] == best_s) begin
        tie_s = 1'b1;
      end else begin
        tie_s = tie_s;
      end
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    roll_cnt_d = roll_cnt_q;
    cat_d      = cat_q;
    round_d    = round_q;
    mask_d     = mask_q;
    score_d    = score_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    trig_d     = 1'b0;
`ifdef YACHT_UPPER_BONUS_EN
    upper_d    = upper_q;
    bonus_d    = bonus_q;
`endif
    case (state_q)
      ST_INIT: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          mask_d[p]  = '0;
          score_d[p] = '0;
`ifdef YACHT_UPPER_BONUS_EN
          upper_d[p] = 7'd0;
          bonus_d[p] = 1'b0;
`endif
        end
        round_d    = 4'd1;
        player_d   = '0;
        roll_cnt_d = 2'd0;
        cat_d      = '0;
        state_d    = ST_TURN_START;
      end
      ST_TURN_START: begin
        roll_cnt_d = 2'd0;
        cat_d      = first_free_s;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (roll_ok_s)                             state_d = ST_ROLL;
        else if (btn_sel && (roll_cnt_q != 2'd0))  state_d = ST_SELECT;
        else                                       state_d = ST_WAIT;
      end
      ST_ROLL: begin
        roll_cnt_d = roll_cnt_q + 2'd1;
        trig_d     = 1'b1;
        state_d    = ((roll_cnt_q + 2'd1) == 2'(MAX_ROLLS)) ? ST_SELECT : ST_WAIT;
      end
      ST_SELECT: begin
        if (btn_sel && any_free_s && !cur_mask_s[cat_q]) state_d = ST_COMMIT;
        else if (btn_next || btn_prev)                   cat_d   = next_free_s;
        else                                             state_d = ST_SELECT;
      end
      ST_COMMIT: begin
        score_d[player_q]        = new_score_s;
        mask_d[player_q][cat_q]  = 1'b1;
`ifdef YACHT_UPPER_BONUS_EN
        if (cat_q < CW'(UPPER_CATS)) begin
          upper_d[player_q] = (upper_sum_s > 9'd127) ? 7'd127 : upper_sum_s[6:0];
          bonus_d[player_q] = bonus_q[player_q] | bonus_hit_s;
        end else begin
          upper_d[player_q] = upper_q[player_q];
        end
`endif
        state_d = ST_NEXT_PLAYER;
      end
      ST_NEXT_PLAYER: begin
        if (player_q != PW'(NUM_PLAYERS - 1)) begin
          player_d = player_q + PW'(1);
          state_d  = ST_TURN_START;
        end else if (round_q == 4'(NUM_CAT)) begin
          winner_d = win_s;
          tie_d    = tie_s;
          state_d  = ST_GAME_END;
        end else begin
          player_d = '0;
          round_d  = round_q + 4'd1;
          state_d  = ST_TURN_START;
        end
      end
      ST_GAME_END: state_d = ST_GAME_END;
      default:     state_d = ST_INIT;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      cs_q       <= 4'd0;
      player_q   <= '0;
      roll_cnt_q <= 2'd0;
      cat_q      <= '0;
      round_q    <= 4'd1;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      trig_q     <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        mask_q[p]  <= '0;
        score_q[p] <= '0;
`ifdef YACHT_UPPER_BONUS_EN
        upper_q[p] <= 7'd0;
        bonus_q[p] <= 1'b0;
`endif
      end
    end else begin
      state_q    <= state_d;
      cs_q       <= state_q;
      player_q   <= player_d;
      roll_cnt_q <= roll_cnt_d;
      cat_q      <= cat_d;
      round_q    <= round_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
      trig_q     <= trig_d;
      mask_q     <= mask_d;
      score_q    <= score_d;
`ifdef YACHT_UPPER_BONUS_EN
      upper_q    <= upper_d;
      bonus_q    <= bonus_d;
`endif
    end
  end

  // Flatten per-player scores onto the output bus.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      scores[p*SCORE_W +: SCORE_W] = score_q[p];
    end
  end

  assign current_state = cs_q;
  assign player_idx    = player_q;
  assign roll_trigger  = trig_q;
  assign roll_cnt      = roll_cnt_q;
  assign dice_clear    = (state_q == ST_TURN_START);
  assign category_idx  = cat_q;
  assign round_num     = round_q;
  assign used_mask     = cur_mask_s;
  assign game_over     = (state_q == ST_GAME_END);
  assign winner_idx    = winner_q;
  assign tie           = tie_q;

endmodule
